// File: rtl/arith_unit_seq_if.sv
// ---------------------------------------------------------------------------
// arith_unit_seq_if : operand/result handshake bundle for arith_unit_seq.
//   Input side : i_valid / o_ready with opcode and two operands.
//   Output side: o_valid / i_ready with full-width result and status flags.
//   slave  modport : the arithmetic unit.
//   master modport : the operand source / result sink driving the unit.
// ---------------------------------------------------------------------------
interface arith_unit_seq_if #(
   parameter int WIDTH = 8
);
   logic             i_valid;
   logic             o_ready;
   logic [1:0]       i_op;
   logic [WIDTH-1:0] i_value_a;
   logic [WIDTH-1:0] i_value_b;
   logic             o_valid;
   logic             i_ready;
   logic [WIDTH-1:0] o_result;
   logic [WIDTH-1:0] o_result_hi;
   logic             o_carry;
   logic             o_div_by_zero;

   modport slave (
      input  i_valid, i_op, i_value_a, i_value_b, i_ready,
      output o_ready, o_valid, o_result, o_result_hi, o_carry, o_div_by_zero
   );

   modport master (
      output i_valid, i_op, i_value_a, i_value_b, i_ready,
      input  o_ready, o_valid, o_result, o_result_hi, o_carry, o_div_by_zero
   );
endinterface

// File: rtl/arith_unit_seq.sv
// ---------------------------------------------------------------------------
// arith_unit_seq : registered unsigned add/sub/mul/div unit.
//   - One transaction at a time, valid/ready on both sides.
//   - add/sub/mul and divide-by-zero complete at the accept edge.
//   - Divide is a restoring divider producing one quotient bit per cycle
//     (WIDTH iterations after the accept edge).
//   - Optional macro ARITH_SATURATE_EN: add/mul clamp to all ones on carry /
//     overflow, sub clamps to zero on borrow; flags still report raw status.
// ---------------------------------------------------------------------------
module arith_unit_seq #(
   parameter int WIDTH = 8,
   parameter int CNT_W = $clog2(WIDTH + 1)
) (
   input logic             i_clk,
   input logic             i_rst_n,
   arith_unit_seq_if.slave bus
);

   localparam logic [1:0] OP_ADD = 2'b00;
   localparam logic [1:0] OP_SUB = 2'b01;
   localparam logic [1:0] OP_MUL = 2'b10;
   localparam logic [1:0] OP_DIV = 2'b11;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t            state;

   // Divider working registers: quo_q starts as the dividend and fills with
   // quotient bits from the right as dividend bits are shifted out the left.
   logic [WIDTH-1:0]  rem_q;
   logic [WIDTH-1:0]  quo_q;
   logic [WIDTH-1:0]  dvs_q;
   logic [CNT_W-1:0]  cnt_q;

   // Single-cycle datapath signals
   logic [WIDTH:0]    sum;
   logic [WIDTH:0]    diff;
   logic [2*WIDTH-1:0] prod;
   logic              mul_ovf;
   logic [WIDTH-1:0]  add_res;
   logic [WIDTH-1:0]  sub_res;
   logic [WIDTH-1:0]  mul_res;
   logic [WIDTH-1:0]  fast_res;
   logic [WIDTH-1:0]  fast_hi;
   logic              fast_carry;
   logic              fast_dbz;
   logic              start_div;

   // One restoring-division step
   logic [WIDTH:0]    trial;
   logic              fit;
   logic [WIDTH-1:0]  step_rem;
   logic [WIDTH-1:0]  step_quo;

   // Single-cycle results (add/sub/mul/div-by-zero) straight from the inputs
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path can
      // leave it unassigned and infer a latch.
      fast_res   = '0;
      fast_hi    = '0;
      fast_carry = 1'b0;
      fast_dbz   = 1'b0;

      sum     = {1'b0, bus.i_value_a} + {1'b0, bus.i_value_b};
      diff    = {1'b0, bus.i_value_a} - {1'b0, bus.i_value_b};
      prod    = {{WIDTH{1'b0}}, bus.i_value_a} * {{WIDTH{1'b0}}, bus.i_value_b};
      mul_ovf = |prod[2*WIDTH-1:WIDTH];

      add_res = sum[WIDTH-1:0];
      sub_res = diff[WIDTH-1:0];
      mul_res = prod[WIDTH-1:0];
`ifdef ARITH_SATURATE_EN
      if (sum[WIDTH])  add_res = '1;
      if (diff[WIDTH]) sub_res = '0;
      if (mul_ovf)     mul_res = '1;
`else
      // Wrapping arithmetic: low WIDTH bits are the result as-is.
`endif

      unique case (bus.i_op)
         OP_ADD: begin
            fast_res   = add_res;
            fast_carry = sum[WIDTH];
         end
         OP_SUB: begin
            fast_res   = sub_res;
            fast_carry = diff[WIDTH];   // borrow: A < B
         end
         OP_MUL: begin
            fast_res   = mul_res;
            fast_hi    = prod[2*WIDTH-1:WIDTH];
            fast_carry = mul_ovf;
         end
         default: begin                 // div by zero shortcut
            fast_res   = '1;
            fast_hi    = bus.i_value_a;
            fast_dbz   = 1'b1;
         end
      endcase

      start_div = (bus.i_op == OP_DIV) && (bus.i_value_b != '0);
   end

   // Restoring step: shift in next dividend MSB, subtract divisor if it fits
   always_comb begin
      trial    = {rem_q, quo_q[WIDTH-1]};
      fit      = (trial >= {1'b0, dvs_q});
      step_rem = fit ? WIDTH'(trial - {1'b0, dvs_q}) : trial[WIDTH-1:0];
      step_quo = {quo_q[WIDTH-2:0], fit};
   end

   // Control FSM with registered handshake and result outputs
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      // NOTE: state and datapath registers update with non-blocking
      // assignments so every register samples pre-edge values.
      if (!i_rst_n) begin
         // NOTE: the divider working registers are cleared too, so an
         // aborted division leaves no trace behind.
         state             <= IDLE;
         bus.o_ready       <= 1'b1;
         bus.o_valid       <= 1'b0;
         bus.o_result      <= '0;
         bus.o_result_hi   <= '0;
         bus.o_carry       <= 1'b0;
         bus.o_div_by_zero <= 1'b0;
         rem_q             <= '0;
         quo_q             <= '0;
         dvs_q             <= '0;
         cnt_q             <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (bus.i_valid) begin
                  bus.o_ready <= 1'b0;
                  if (start_div) begin
                     rem_q <= '0;
                     quo_q <= bus.i_value_a;
                     dvs_q <= bus.i_value_b;
                     cnt_q <= CNT_W'(WIDTH);
                     state <= CALC;
                  end else begin
                     bus.o_result      <= fast_res;
                     bus.o_result_hi   <= fast_hi;
                     bus.o_carry       <= fast_carry;
                     bus.o_div_by_zero <= fast_dbz;
                     bus.o_valid       <= 1'b1;
                     state             <= DONE;
                  end
               end
            end
            CALC: begin
               rem_q <= step_rem;
               quo_q <= step_quo;
               cnt_q <= cnt_q - CNT_W'(1);
               if (cnt_q == CNT_W'(1)) begin
                  bus.o_result      <= step_quo;
                  bus.o_result_hi   <= step_rem;
                  bus.o_carry       <= 1'b0;
                  bus.o_div_by_zero <= 1'b0;
                  bus.o_valid       <= 1'b1;
                  state             <= DONE;
               end
            end
            DONE: begin
               if (bus.i_ready) begin
                  bus.o_valid <= 1'b0;
                  bus.o_ready <= 1'b1;
                  state       <= IDLE;
               end
            end
            default: begin
               bus.o_valid <= 1'b0;
               bus.o_ready <= 1'b1;
               state       <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_arith_unit_seq.sv
// ---------------------------------------------------------------------------
// tb_arith_unit_seq : directed vector bench for arith_unit_seq (WIDTH=8).
//   Table of hand-computed vectors plus sequences for backpressure and
//   reset during a division. Honors ARITH_SATURATE_EN when defined.
// ---------------------------------------------------------------------------
module tb_arith_unit_seq;

   localparam int WIDTH = 8;
`ifdef ARITH_SATURATE_EN
   localparam bit SAT = 1'b1;
`else
   localparam bit SAT = 1'b0;
`endif

   typedef struct {
      logic [1:0] op;
      logic [7:0] a;
      logic [7:0] b;
      logic [7:0] res_wrap;
      logic [7:0] res_sat;
      logic [7:0] hi;
      logic       carry;
      logic       dbz;
      int         lat;
   } vec_t;

   logic i_clk = 1'b0;
   logic i_rst_n;
   int   errors = 0;
   int   checks = 0;

   arith_unit_seq_if #(.WIDTH(WIDTH)) bus ();

   arith_unit_seq #(.WIDTH(WIDTH)) dut (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .bus     (bus)
   );

   always #5 i_clk = ~i_clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Present a transaction at a negedge, then measure accept-to-valid latency.
   // Returns at a negedge with o_valid expected high.
   task automatic issue(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                        output int lat);
      bus.i_op      = op;
      bus.i_value_a = a;
      bus.i_value_b = b;
      bus.i_valid   = 1'b1;
      check("ready before accept", 32'(bus.o_ready), 32'd1);
      @(posedge i_clk);
      @(negedge i_clk);
      // Scramble inputs: they must be ignored from now on.
      bus.i_valid   = 1'b0;
      bus.i_op      = ~op;
      bus.i_value_a = ~a;
      bus.i_value_b = a ^ b;
      lat = 1;
      while (!bus.o_valid && lat < 40) begin
         check("ready low in calc", 32'(bus.o_ready), 32'd0);
         @(posedge i_clk);
         @(negedge i_clk);
         lat++;
      end
      check("valid within bound", 32'(bus.o_valid), 32'd1);
      check("ready low in done", 32'(bus.o_ready), 32'd0);
   endtask

   // Hand the result to the sink; returns at a negedge back in IDLE.
   task automatic release_result();
      bus.i_ready = 1'b1;
      @(posedge i_clk);
      @(negedge i_clk);
      bus.i_ready = 1'b0;
      check("valid drops after release", 32'(bus.o_valid), 32'd0);
      check("ready back after release", 32'(bus.o_ready), 32'd1);
   endtask

   vec_t vecs[14];

   initial begin
      int lat;
      logic [7:0] held;

      vecs[0]  = '{2'd0, 8'd200, 8'd100, 8'd44,  8'd255, 8'd0,   1'b1, 1'b0, 1};
      vecs[1]  = '{2'd0, 8'd10,  8'd20,  8'd30,  8'd30,  8'd0,   1'b0, 1'b0, 1};
      vecs[2]  = '{2'd0, 8'd255, 8'd1,   8'd0,   8'd255, 8'd0,   1'b1, 1'b0, 1};
      vecs[3]  = '{2'd1, 8'd5,   8'd10,  8'd251, 8'd0,   8'd0,   1'b1, 1'b0, 1};
      vecs[4]  = '{2'd1, 8'd10,  8'd5,   8'd5,   8'd5,   8'd0,   1'b0, 1'b0, 1};
      vecs[5]  = '{2'd1, 8'd7,   8'd7,   8'd0,   8'd0,   8'd0,   1'b0, 1'b0, 1};
      vecs[6]  = '{2'd2, 8'd200, 8'd3,   8'd88,  8'd255, 8'd2,   1'b1, 1'b0, 1};
      vecs[7]  = '{2'd2, 8'd15,  8'd15,  8'd225, 8'd225, 8'd0,   1'b0, 1'b0, 1};
      vecs[8]  = '{2'd2, 8'd255, 8'd255, 8'd1,   8'd255, 8'd254, 1'b1, 1'b0, 1};
      vecs[9]  = '{2'd3, 8'd100, 8'd7,   8'd14,  8'd14,  8'd2,   1'b0, 1'b0, 9};
      vecs[10] = '{2'd3, 8'd55,  8'd0,   8'd255, 8'd255, 8'd55,  1'b0, 1'b1, 1};
      vecs[11] = '{2'd3, 8'd255, 8'd1,   8'd255, 8'd255, 8'd0,   1'b0, 1'b0, 9};
      vecs[12] = '{2'd3, 8'd3,   8'd10,  8'd0,   8'd0,   8'd3,   1'b0, 1'b0, 9};
      vecs[13] = '{2'd3, 8'd200, 8'd3,   8'd66,  8'd66,  8'd2,   1'b0, 1'b0, 9};

      // Reset state
      i_rst_n       = 1'b0;
      bus.i_valid   = 1'b0;
      bus.i_ready   = 1'b0;
      bus.i_op      = 2'd0;
      bus.i_value_a = 8'd0;
      bus.i_value_b = 8'd0;
      #1;
      check("reset valid", 32'(bus.o_valid), 32'd0);
      check("reset result", 32'(bus.o_result), 32'd0);
      check("reset result_hi", 32'(bus.o_result_hi), 32'd0);
      check("reset carry", 32'(bus.o_carry), 32'd0);
      check("reset div_by_zero", 32'(bus.o_div_by_zero), 32'd0);
      repeat (2) @(negedge i_clk);
      i_rst_n = 1'b1;
      @(negedge i_clk);
      check("ready after reset", 32'(bus.o_ready), 32'd1);
      check("valid after reset", 32'(bus.o_valid), 32'd0);

      // Table-driven vectors
      for (int i = 0; i < 14; i++) begin
         issue(vecs[i].op, vecs[i].a, vecs[i].b, lat);
         check($sformatf("v%0d result", i), 32'(bus.o_result),
               32'(SAT ? vecs[i].res_sat : vecs[i].res_wrap));
         check($sformatf("v%0d result_hi", i), 32'(bus.o_result_hi), 32'(vecs[i].hi));
         check($sformatf("v%0d carry", i), 32'(bus.o_carry), 32'(vecs[i].carry));
         check($sformatf("v%0d div_by_zero", i), 32'(bus.o_div_by_zero), 32'(vecs[i].dbz));
         check($sformatf("v%0d latency", i), 32'(lat), 32'(vecs[i].lat));
         release_result();
      end

      // Backpressure: hold DONE for 5 cycles while offering a new transaction
      issue(2'd0, 8'd200, 8'd100, lat);
      held = SAT ? 8'd255 : 8'd44;
      for (int k = 0; k < 5; k++) begin
         bus.i_valid   = 1'b1;
         bus.i_op      = 2'd2;
         bus.i_value_a = 8'd9;
         bus.i_value_b = 8'd9;
         @(posedge i_clk);
         @(negedge i_clk);
         check($sformatf("bp%0d valid", k), 32'(bus.o_valid), 32'd1);
         check($sformatf("bp%0d ready", k), 32'(bus.o_ready), 32'd0);
         check($sformatf("bp%0d result", k), 32'(bus.o_result), 32'(held));
         check($sformatf("bp%0d carry", k), 32'(bus.o_carry), 32'd1);
      end
      bus.i_valid = 1'b0;
      release_result();
      @(posedge i_clk);
      @(negedge i_clk);
      check("bp no stray accept", 32'(bus.o_valid), 32'd0);
      check("bp still idle", 32'(bus.o_ready), 32'd1);
      check("bp result held", 32'(bus.o_result), 32'(held));

      // Reset during the 4th CALC cycle of 200/3
      bus.i_op      = 2'd3;
      bus.i_value_a = 8'd200;
      bus.i_value_b = 8'd3;
      bus.i_valid   = 1'b1;
      @(posedge i_clk);
      @(negedge i_clk);
      bus.i_valid = 1'b0;
      check("abort in calc", 32'(bus.o_ready), 32'd0);
      repeat (3) @(posedge i_clk);
      @(negedge i_clk);
      i_rst_n = 1'b0;
      #1;
      check("abort valid", 32'(bus.o_valid), 32'd0);
      check("abort result", 32'(bus.o_result), 32'd0);
      check("abort result_hi", 32'(bus.o_result_hi), 32'd0);
      @(negedge i_clk);
      i_rst_n = 1'b1;
      for (int k = 0; k < 10; k++) begin
         @(negedge i_clk);
         check($sformatf("abort quiet%0d", k), 32'(bus.o_valid), 32'd0);
      end
      check("abort ready", 32'(bus.o_ready), 32'd1);

      issue(2'd3, 8'd200, 8'd3, lat);
      check("rediv result", 32'(bus.o_result), 32'd66);
      check("rediv result_hi", 32'(bus.o_result_hi), 32'd2);
      check("rediv latency", 32'(lat), 32'd9);
      release_result();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
